// File: rtl/rd_if_pkg.sv
// Shared types and defaults for the go/rd/ws/ds read handshake target.
package rd_if_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      READY
   } state_t;

   localparam int unsigned DW_DEF = 8;
   localparam int unsigned AW_DEF = 4;
   localparam int unsigned WW_DEF = 4;

   localparam logic [DW_DEF-1:0] OOR_DATA = '0;

endpackage

// File: rtl/rd_resp_mem.sv
// Preloadable word store: synchronous write, combinational read, range check.
module rd_resp_mem
   import rd_if_pkg::*;
#(
   parameter int unsigned DW    = DW_DEF,
   parameter int unsigned AW    = AW_DEF,
   parameter int unsigned DEPTH = 12
) (
   input  logic          clk_i,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [DW-1:0] wr_data_i,
   input  logic [AW-1:0] rd_addr_i,
   output logic [DW-1:0] rd_data_o,
   output logic          rd_oor_o
);

   logic [DW-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (wr_en_i && (int'(wr_addr_i) < DEPTH)) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Read sees pre-edge contents, so a same-cycle write returns the old word.
   always_comb begin
      rd_oor_o  = (int'(rd_addr_i) >= DEPTH);
      rd_data_o = DW'(OOR_DATA);
      if (!rd_oor_o) begin
         rd_data_o = mem_q[rd_addr_i];
      end
   end

endmodule

// File: rtl/rd_responder.sv
// Target side of the rd/ws/ds read handshake: wait-state stretching,
// registered read data, address/abort error and protocol error pulses.
module rd_responder
   import rd_if_pkg::*;
#(
   parameter int unsigned DW      = DW_DEF,
   parameter int unsigned AW      = AW_DEF,
   parameter int unsigned DEPTH   = 12,
   parameter int unsigned WW      = WW_DEF,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          rd,
   input  logic          ds,
   input  logic [AW-1:0] addr,
   input  logic [WW-1:0] wait_cfg,
   output logic          ws,
   output logic [DW-1:0] rdata,
   output logic          busy,
   output logic          err,
   output logic          proto_err,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data
);

   localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   state_t        state_q;
   logic          ws_q;
   logic [DW-1:0] rdata_q;
   logic          busy_q;
   logic          err_q;
   logic          proto_err_q;
   logic          oor_q;
   logic [WW-1:0] wcnt_q;
   logic [TW-1:0] tcnt_q;

   logic [DW-1:0] mem_rdata;
   logic          mem_oor;

   rd_resp_mem #(
      .DW   (DW),
      .AW   (AW),
      .DEPTH(DEPTH)
   ) u_mem (
      .clk_i    (clk),
      .wr_en_i  (wr_en),
      .wr_addr_i(wr_addr),
      .wr_data_i(wr_data),
      .rd_addr_i(addr),
      .rd_data_o(mem_rdata),
      .rd_oor_o (mem_oor)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ws_q        <= 1'b0;
         rdata_q     <= '0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
         proto_err_q <= 1'b0;
         oor_q       <= 1'b0;
         wcnt_q      <= '0;
         tcnt_q      <= '0;
      end else begin
         err_q       <= 1'b0;
         proto_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (rd) begin
                  rdata_q <= mem_rdata;
                  oor_q   <= mem_oor;
                  wcnt_q  <= wait_cfg;
                  tcnt_q  <= '0;
                  busy_q  <= 1'b1;
                  if (wait_cfg != '0) begin
                     state_q <= WAIT;
                     ws_q    <= 1'b1;
                  end else begin
                     state_q <= READY;
                     ws_q    <= 1'b0;
                  end
               end else if (ds) begin
                  proto_err_q <= 1'b1;
               end
            end
            WAIT: begin
               // An early ds is flagged but does not disturb the countdown.
               if (ds) begin
                  proto_err_q <= 1'b1;
               end
               if (!rd && !ds) begin
                  state_q <= IDLE;
                  ws_q    <= 1'b0;
                  busy_q  <= 1'b0;
                  err_q   <= 1'b1;
               end else begin
                  wcnt_q <= wcnt_q - 1'b1;
                  if (wcnt_q == WW'(1)) begin
                     state_q <= READY;
                     ws_q    <= 1'b0;
                  end
               end
            end
            READY: begin
               if (ds) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  err_q   <= oor_q;
               end else if (!rd || (tcnt_q == TW'(TIMEOUT - 1))) begin
                  state_q <= IDLE;
                  ws_q    <= 1'b0;
                  busy_q  <= 1'b0;
                  err_q   <= 1'b1;
               end else begin
                  tcnt_q <= tcnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               ws_q    <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ws        = ws_q;
   assign rdata     = rdata_q;
   assign busy      = busy_q;
   assign err       = err_q;
   assign proto_err = proto_err_q;

endmodule

// File: tb/tb_rd_responder.sv
// Bench for rd_responder: timeline-based access model plus directed checks.
module tb_rd_responder;

   localparam int DEPTH   = 12;
   localparam int TIMEOUT = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rd = 1'b0;
   logic       ds = 1'b0;
   logic [3:0] addr = '0;
   logic [3:0] wait_cfg = '0;
   logic       wr_en = 1'b0;
   logic [3:0] wr_addr = '0;
   logic [7:0] wr_data = '0;
   logic       ws;
   logic [7:0] rdata;
   logic       busy;
   logic       err;
   logic       proto_err;

   rd_responder #(
      .DW     (8),
      .AW     (4),
      .DEPTH  (DEPTH),
      .WW     (4),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd       (rd),
      .ds       (ds),
      .addr     (addr),
      .wait_cfg (wait_cfg),
      .ws       (ws),
      .rdata    (rdata),
      .busy     (busy),
      .err      (err),
      .proto_err(proto_err),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   bit check_on = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: an access is described by its start edge and wait count;
   // phase and outputs follow from the elapsed edge count.
   int         cyc = 0;
   bit         m_active = 1'b0;
   int         m_t0 = 0;
   int         m_n = 0;
   int         m_k = 0;
   bit         m_oor = 1'b0;
   logic [7:0] m_rdata = '0;
   bit         m_err = 1'b0;
   bit         m_perr = 1'b0;
   logic [7:0] m_mem [DEPTH];

   always @(posedge clk) begin
      cyc++;
      if (!rst_n) begin
         m_active = 1'b0;
         m_rdata  = '0;
         m_err    = 1'b0;
         m_perr   = 1'b0;
      end else begin
         m_err  = 1'b0;
         m_perr = 1'b0;
         if (!m_active) begin
            if (rd) begin
               m_active = 1'b1;
               m_t0     = cyc;
               m_n      = int'(wait_cfg);
               m_oor    = (int'(addr) >= DEPTH);
               m_rdata  = m_oor ? 8'h00 : m_mem[addr];
            end else if (ds) begin
               m_perr = 1'b1;
            end
         end else begin
            m_k = cyc - m_t0;
            if (m_k <= m_n) begin
               if (ds) m_perr = 1'b1;
               else if (!rd) begin
                  m_active = 1'b0;
                  m_err    = 1'b1;
               end
            end else begin
               if (ds) begin
                  m_active = 1'b0;
                  m_err    = m_oor;
               end else if (!rd || (m_k - m_n == TIMEOUT)) begin
                  m_active = 1'b0;
                  m_err    = 1'b1;
               end
            end
         end
      end
      if (wr_en && int'(wr_addr) < DEPTH) m_mem[wr_addr] = wr_data;
   end

   always @(negedge clk) begin
      if (check_on) begin
         chk("m_ws",    32'(ws),        rst_n ? 32'(m_active && ((cyc - m_t0) < m_n)) : 32'd0);
         chk("m_busy",  32'(busy),      rst_n ? 32'(m_active) : 32'd0);
         chk("m_rdata", 32'(rdata),     rst_n ? 32'(m_rdata) : 32'd0);
         chk("m_err",   32'(err),       rst_n ? 32'(m_err) : 32'd0);
         chk("m_perr",  32'(proto_err), rst_n ? 32'(m_perr) : 32'd0);
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic logic [7:0] pre_val(input int i);
      case (i)
         3:       return 8'hA5;
         5:       return 8'h3C;
         7:       return 8'h77;
         default: return 8'(i * 16 + 1);
      endcase
   endfunction

   // Initiator loop: hold rd, poll ws, pulse ds once ws is low.
   task automatic do_access(input logic [3:0] a, input logic [3:0] w, input logic [7:0] exp);
      int i;
      addr = a; wait_cfg = w; rd = 1'b1;
      tick();
      i = 0;
      while (ws !== 1'b0 && i < 64) begin
         tick();
         i++;
      end
      if (i >= 64) chk("ws_bound", 32'(ws), 32'd0);
      chk("acc_rdata", 32'(rdata), 32'(exp));
      ds = 1'b1;
      tick();
      ds = 1'b0; rd = 1'b0;
      tick();
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) tick();
      chk("rst_ws", 32'(ws), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rdata", 32'(rdata), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      rst_n = 1'b1;
      check_on = 1'b1;

      for (int i = 0; i < DEPTH; i++) begin
         wr_en = 1'b1; wr_addr = 4'(i); wr_data = pre_val(i);
         tick();
      end
      wr_en = 1'b1; wr_addr = 4'd14; wr_data = 8'hFF;
      tick();
      wr_en = 1'b0;
      tick();

      // zero-wait read of 0xA5
      addr = 4'd3; wait_cfg = 4'd0; rd = 1'b1;
      tick();
      chk("t1_ws", 32'(ws), 32'd0);
      chk("t1_rdata", 32'(rdata), 32'hA5);
      chk("t1_busy", 32'(busy), 32'd1);
      ds = 1'b1;
      tick();
      ds = 1'b0; rd = 1'b0;
      chk("t1_busy_after", 32'(busy), 32'd0);
      chk("t1_err", 32'(err), 32'd0);
      tick();

      // three wait states
      addr = 4'd5; wait_cfg = 4'd3; rd = 1'b1;
      tick(); chk("t2_ws1", 32'(ws), 32'd1);
      tick(); chk("t2_ws2", 32'(ws), 32'd1);
      tick(); chk("t2_ws3", 32'(ws), 32'd1);
      tick(); chk("t2_ws4", 32'(ws), 32'd0);
      chk("t2_rdata", 32'(rdata), 32'h3C);
      ds = 1'b1;
      tick();
      ds = 1'b0; rd = 1'b0;
      chk("t2_busy_after", 32'(busy), 32'd0);
      tick();

      // out-of-range address
      addr = 4'd14; wait_cfg = 4'd1; rd = 1'b1;
      tick(); chk("t3_ws1", 32'(ws), 32'd1);
      tick(); chk("t3_ws2", 32'(ws), 32'd0);
      chk("t3_rdata", 32'(rdata), 32'h00);
      ds = 1'b1;
      tick();
      ds = 1'b0; rd = 1'b0;
      chk("t3_err", 32'(err), 32'd1);
      chk("t3_busy", 32'(busy), 32'd0);
      tick();
      chk("t3_err_clr", 32'(err), 32'd0);

      // timeout with rd held and no ds
      addr = 4'd2; wait_cfg = 4'd0; rd = 1'b1;
      repeat (16) tick();
      chk("t4_busy15", 32'(busy), 32'd1);
      chk("t4_err15", 32'(err), 32'd0);
      tick();
      chk("t4_busy16", 32'(busy), 32'd0);
      chk("t4_err16", 32'(err), 32'd1);
      rd = 1'b0;
      tick();
      chk("t4_err_clr", 32'(err), 32'd0);
      chk("t4_busy_idle", 32'(busy), 32'd0);

      // write to the read address in the start cycle
      addr = 4'd7; wait_cfg = 4'd0; rd = 1'b1;
      wr_en = 1'b1; wr_addr = 4'd7; wr_data = 8'h11;
      tick();
      wr_en = 1'b0;
      chk("t5_old", 32'(rdata), 32'h77);
      ds = 1'b1;
      tick();
      ds = 1'b0; rd = 1'b0;
      tick();
      tick();
      addr = 4'd7; rd = 1'b1;
      tick();
      chk("t5_new", 32'(rdata), 32'h11);
      ds = 1'b1;
      tick();
      ds = 1'b0; rd = 1'b0;
      tick();

      // ds while idle
      ds = 1'b1;
      tick();
      ds = 1'b0;
      chk("t6_perr", 32'(proto_err), 32'd1);
      chk("t6_busy", 32'(busy), 32'd0);
      tick();
      chk("t6_perr_clr", 32'(proto_err), 32'd0);

      // ds during wait states is flagged and ignored
      addr = 4'd3; wait_cfg = 4'd4; rd = 1'b1;
      tick();
      tick();
      ds = 1'b1;
      tick();
      ds = 1'b0;
      chk("t7_perr", 32'(proto_err), 32'd1);
      chk("t7_busy", 32'(busy), 32'd1);
      chk("t7_ws", 32'(ws), 32'd1);
      do_access(4'd3, 4'd4, 8'hA5);

      // reset in the middle of wait states
      addr = 4'd5; wait_cfg = 4'd5; rd = 1'b1;
      tick();
      tick();
      chk("t8_ws_pre", 32'(ws), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("t8_ws", 32'(ws), 32'd0);
      chk("t8_busy", 32'(busy), 32'd0);
      chk("t8_rdata", 32'(rdata), 32'd0);
      rd = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      do_access(4'd5, 4'd2, 8'h3C);
      do_access(4'd9, 4'd0, pre_val(9));

      check_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d failed so far", fails);
      $fatal(1);
   end

endmodule
